// File: rtl/router_output_arbiter_if.sv
// Handshake and status bundle between the five input sources, the downstream
// credit return path and one router output port arbiter.
interface router_output_arbiter_if #(
  parameter int CREDIT_BITS = 6
);
  logic                   route_req_a_in, route_req_b_in, route_req_c_in;
  logic                   route_req_d_in, route_req_x_in;
  logic                   valid_a_in, valid_b_in, valid_c_in, valid_d_in, valid_x_in;
  logic                   tail_a_in, tail_b_in, tail_c_in, tail_d_in, tail_x_in;
  logic                   yummy_in;
  logic                   thanks_a_out, thanks_b_out, thanks_c_out;
  logic                   thanks_d_out, thanks_x_out;
  logic [2:0]             current_route;
  logic                   valid_out;
  logic                   locked;
  logic [CREDIT_BITS-1:0] credit_count;
  logic                   ec_wants_to_send_but_cannot;
  logic                   stall_out;

  // Source / downstream side: presents flits and credits, observes grants.
  modport master (
    output route_req_a_in, route_req_b_in, route_req_c_in, route_req_d_in, route_req_x_in,
    output valid_a_in, valid_b_in, valid_c_in, valid_d_in, valid_x_in,
    output tail_a_in, tail_b_in, tail_c_in, tail_d_in, tail_x_in,
    output yummy_in,
    input  thanks_a_out, thanks_b_out, thanks_c_out, thanks_d_out, thanks_x_out,
    input  current_route, valid_out, locked, credit_count,
    input  ec_wants_to_send_but_cannot, stall_out
  );

  // Arbiter side.
  modport slave (
    input  route_req_a_in, route_req_b_in, route_req_c_in, route_req_d_in, route_req_x_in,
    input  valid_a_in, valid_b_in, valid_c_in, valid_d_in, valid_x_in,
    input  tail_a_in, tail_b_in, tail_c_in, tail_d_in, tail_x_in,
    input  yummy_in,
    output thanks_a_out, thanks_b_out, thanks_c_out, thanks_d_out, thanks_x_out,
    output current_route, valid_out, locked, credit_count,
    output ec_wants_to_send_but_cannot, stall_out
  );
endinterface

// File: rtl/router_output_arbiter.sv
// Wormhole round-robin arbiter and credit scheduler for one router output.
// Sources A,B,C,D,X map to route codes 0..4. A winner holds the port until its
// tail flit is launched; flits are metered against downstream credits.
// Optional stall monitor: define ROUTER_OUT_ARB_STALL_MON_EN.
module router_output_arbiter #(
  parameter int CREDIT_CNT  = 32,
  parameter int CREDIT_BITS = 6,
  parameter int STALL_LIMIT = 255,
  parameter int STALL_BITS  = 8
) (
  input logic                     clk,
  input logic                     reset,
  router_output_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [2:0]             ROUTE_X    = 3'd4;
  localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = CREDIT_BITS'(CREDIT_CNT);

  state_t                 state_q, state_d;
  logic [2:0]             current_route_q, current_route_d;
  logic [2:0]             last_grant_q, last_grant_d;
  logic [CREDIT_BITS-1:0] credit_q, credit_d;

  logic [4:0] req_vec, valid_vec, tail_vec, thanks_vec;
  logic       valid_sel, tail_sel, fire, ec;
  logic       grant_found;
  logic [2:0] grant_idx;

  assign req_vec   = {bus.route_req_x_in & bus.valid_x_in, bus.route_req_d_in & bus.valid_d_in,
                      bus.route_req_c_in & bus.valid_c_in, bus.route_req_b_in & bus.valid_b_in,
                      bus.route_req_a_in & bus.valid_a_in};
  assign valid_vec = {bus.valid_x_in, bus.valid_d_in, bus.valid_c_in, bus.valid_b_in, bus.valid_a_in};
  assign tail_vec  = {bus.tail_x_in, bus.tail_d_in, bus.tail_c_in, bus.tail_b_in, bus.tail_a_in};

  // Select the locked source's valid/tail; codes 5..7 never occur.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    valid_sel = 1'b0;
    tail_sel  = 1'b0;
    case (current_route_q)
      3'd0: begin valid_sel = valid_vec[0]; tail_sel = tail_vec[0]; end
      3'd1: begin valid_sel = valid_vec[1]; tail_sel = tail_vec[1]; end
      3'd2: begin valid_sel = valid_vec[2]; tail_sel = tail_vec[2]; end
      3'd3: begin valid_sel = valid_vec[3]; tail_sel = tail_vec[3]; end
      3'd4: begin valid_sel = valid_vec[4]; tail_sel = tail_vec[4]; end
      default: ;
    endcase
  end

  assign fire       = (state_q == LOCKED) & valid_sel & (credit_q != '0);
  assign ec         = (state_q == LOCKED) & valid_sel & (credit_q == '0);
  assign thanks_vec = fire ? (5'b00001 << current_route_q) : 5'b00000;

  // Round-robin search starting one past the last granted source, wrapping A..X.
  always_comb begin
    logic [3:0] sum;
    logic [2:0] cand;
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    sum         = '0;
    cand        = '0;
    for (int off = 1; off <= 5; off++) begin
      sum  = {1'b0, last_grant_q} + 4'(off);
      cand = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
      if (!grant_found && req_vec[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Lock FSM next state: arbitrate in IDLE, release on a launched tail flit.
  always_comb begin
    state_d         = state_q;
    current_route_d = current_route_q;
    last_grant_d    = last_grant_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          current_route_d = grant_idx;
          state_d         = LOCKED;
        end
      end
      LOCKED: begin
        if (fire && tail_sel) begin
          last_grant_d = current_route_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit counter: launch consumes, yummy returns, both cancel; saturates at full.
  always_comb begin
    credit_d = credit_q;
    if (fire && !bus.yummy_in) begin
      credit_d = credit_q - 1'b1;
    end else if (bus.yummy_in && !fire && (credit_q != CREDIT_MAX)) begin
      credit_d = credit_q + 1'b1;
    end
  end

  // State, route, last grant and credit registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q         <= IDLE;
      current_route_q <= ROUTE_X;
      last_grant_q    <= ROUTE_X;
      credit_q        <= CREDIT_MAX;
    end else begin
      state_q         <= state_d;
      current_route_q <= current_route_d;
      last_grant_q    <= last_grant_d;
      credit_q        <= credit_d;
    end
  end

`ifdef ROUTER_OUT_ARB_STALL_MON_EN
  localparam logic [STALL_BITS-1:0] STALL_MAX = STALL_BITS'(STALL_LIMIT);

  logic [STALL_BITS-1:0] stall_cnt_q, stall_cnt_d;
  logic                  stall_q;

  // Count consecutive credit-starved cycles; any launch clears the count.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (fire) begin
      stall_cnt_d = '0;
    end else if (ec && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Stall flag is registered from the saturated count and drops on a launch.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      stall_q     <= !fire && (stall_cnt_q == STALL_MAX);
    end
  end

  assign bus.stall_out = stall_q;
`else
  assign bus.stall_out = 1'b0;
`endif

  assign bus.thanks_a_out                = thanks_vec[0];
  assign bus.thanks_b_out                = thanks_vec[1];
  assign bus.thanks_c_out                = thanks_vec[2];
  assign bus.thanks_d_out                = thanks_vec[3];
  assign bus.thanks_x_out                = thanks_vec[4];
  assign bus.current_route               = current_route_q;
  assign bus.valid_out                   = fire;
  assign bus.locked                      = (state_q == LOCKED);
  assign bus.credit_count                = credit_q;
  assign bus.ec_wants_to_send_but_cannot = ec;

endmodule

// File: tb/tb_router_output_arbiter.sv
// Directed bench for router_output_arbiter: lock/release, round-robin order,
// credit metering, gapped packets, mid-packet reset and the stall monitor.
module tb_router_output_arbiter;

`ifdef ROUTER_OUT_ARB_STALL_MON_EN
  localparam logic STALL_EN  = 1'b1;
  localparam int   STALL_LIM = 4;
`else
  localparam logic STALL_EN  = 1'b0;
  localparam int   STALL_LIM = 255;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] req_v, val_v, tail_v;
  logic       yummy_v;
  int         total = 0;
  int         bad   = 0;

  router_output_arbiter_if #(.CREDIT_BITS(6)) bus ();

  router_output_arbiter #(
    .CREDIT_CNT (32),
    .CREDIT_BITS(6),
    .STALL_LIMIT(STALL_LIM),
    .STALL_BITS (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign bus.route_req_a_in = req_v[0];
  assign bus.route_req_b_in = req_v[1];
  assign bus.route_req_c_in = req_v[2];
  assign bus.route_req_d_in = req_v[3];
  assign bus.route_req_x_in = req_v[4];
  assign bus.valid_a_in     = val_v[0];
  assign bus.valid_b_in     = val_v[1];
  assign bus.valid_c_in     = val_v[2];
  assign bus.valid_d_in     = val_v[3];
  assign bus.valid_x_in     = val_v[4];
  assign bus.tail_a_in      = tail_v[0];
  assign bus.tail_b_in      = tail_v[1];
  assign bus.tail_c_in      = tail_v[2];
  assign bus.tail_d_in      = tail_v[3];
  assign bus.tail_x_in      = tail_v[4];
  assign bus.yummy_in       = yummy_v;

  logic [4:0] thanks;
  assign thanks = {bus.thanks_x_out, bus.thanks_d_out, bus.thanks_c_out,
                   bus.thanks_b_out, bus.thanks_a_out};

  // Route codes 5..7 must never appear.
  always @(negedge clk) begin
    if (!reset) assert (bus.current_route <= 3'd4)
      else $error("FAIL route_range: got=%0d need<=4", bus.current_route);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req_v = '0; val_v = '0; tail_v = '0; yummy_v = 1'b0;
  endtask

  logic [2:0] rr_order [6];

  initial begin
    rr_order = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    sample();
    check("rst_locked",  32'(bus.locked), 32'd0);
    check("rst_route",   32'(bus.current_route), 32'd4);
    check("rst_credit",  32'(bus.credit_count), 32'd32);
    check("rst_valid",   32'(bus.valid_out), 32'd0);
    check("rst_thanks",  32'(thanks), 32'd0);
    check("rst_ec",      32'(bus.ec_wants_to_send_but_cannot), 32'd0);
    check("rst_stall",   32'(bus.stall_out), 32'd0);
    tick();
    reset = 1'b0;

    // A alone, 3-flit packet.
    req_v[0] = 1'b1; val_v[0] = 1'b1;
    sample();
    check("a_arb_locked", 32'(bus.locked), 32'd0);
    check("a_arb_valid",  32'(bus.valid_out), 32'd0);
    tick();
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) tail_v[0] = 1'b1;
      sample();
      check($sformatf("a_f%0d_locked", i), 32'(bus.locked), 32'd1);
      check($sformatf("a_f%0d_valid", i),  32'(bus.valid_out), 32'd1);
      check($sformatf("a_f%0d_thanks", i), 32'(thanks), 32'h01);
      tick();
    end
    clear_inputs();
    sample();
    check("a_done_locked", 32'(bus.locked), 32'd0);
    check("a_done_credit", 32'(bus.credit_count), 32'd29);
    tick();

    // Fresh reset so the round-robin pointer starts at X.
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // All five request single-flit packets continuously.
    req_v = 5'h1f; val_v = 5'h1f; tail_v = 5'h1f;
    for (int k = 0; k < 12; k++) begin
      sample();
      if (k % 2 == 1) begin
        check($sformatf("rr%0d_route", k),  32'(bus.current_route), 32'(rr_order[k/2]));
        check($sformatf("rr%0d_thanks", k), 32'(thanks), 32'(5'b00001 << rr_order[k/2]));
      end else begin
        check($sformatf("rr%0d_valid", k), 32'(bus.valid_out), 32'd0);
      end
      tick();
    end
    clear_inputs();
    sample();
    check("rr_credit", 32'(bus.credit_count), 32'd26);
    tick();

    // Drain credits with A locked on a long packet.
    req_v[0] = 1'b1; val_v[0] = 1'b1;
    tick();
    for (int i = 0; i < 26; i++) tick();
    for (int i = 0; i < 5; i++) begin
      sample();
      check($sformatf("dry%0d_ec", i), 32'(bus.ec_wants_to_send_but_cannot), 32'd1);
      if (i == 0) begin
        check("dry_valid",  32'(bus.valid_out), 32'd0);
        check("dry_thanks", 32'(thanks), 32'd0);
        check("dry_credit", 32'(bus.credit_count), 32'd0);
      end
      tick();
    end
    yummy_v = 1'b1;
    sample();
    check("stall_set",   32'(bus.stall_out), 32'(STALL_EN));
    check("yummy_valid", 32'(bus.valid_out), 32'd0);
    tick();
    yummy_v = 1'b0;
    sample();
    check("one_flit_valid",  32'(bus.valid_out), 32'd1);
    check("one_flit_thanks", 32'(thanks), 32'h01);
    tick();
    sample();
    check("one_flit_only", 32'(bus.valid_out), 32'd0);
    check("stall_clear",   32'(bus.stall_out), 32'd0);
    check("redry_credit",  32'(bus.credit_count), 32'd0);
    tick();

    // Refill to 5, then launch the tail while a credit returns.
    val_v[0] = 1'b0; yummy_v = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    val_v[0] = 1'b1; tail_v[0] = 1'b1;
    sample();
    check("both_valid",      32'(bus.valid_out), 32'd1);
    check("both_credit_pre", 32'(bus.credit_count), 32'd5);
    tick();
    clear_inputs();
    sample();
    check("both_credit", 32'(bus.credit_count), 32'd5);
    check("both_locked", 32'(bus.locked), 32'd0);
    tick();

    // Refill to full, then one extra yummy must saturate.
    yummy_v = 1'b1;
    for (int i = 0; i < 27; i++) tick();
    $display("note: returning a credit at full count (protocol error case)");
    tick();
    yummy_v = 1'b0;
    sample();
    check("sat_credit", 32'(bus.credit_count), 32'd32);
    tick();

    // C locked with a gap; A waits and must not be granted before C's tail.
    req_v[2] = 1'b1; val_v[2] = 1'b1;
    sample();
    check("c_arb_locked", 32'(bus.locked), 32'd0);
    tick();
    req_v[0] = 1'b1; val_v[0] = 1'b1;
    sample();
    check("c_f1_route",  32'(bus.current_route), 32'd2);
    check("c_f1_thanks", 32'(thanks), 32'h04);
    tick();
    req_v[2] = 1'b0; val_v[2] = 1'b0;
    sample();
    check("c_gap_thanks", 32'(thanks), 32'h00);
    check("c_gap_locked", 32'(bus.locked), 32'd1);
    check("c_gap_route",  32'(bus.current_route), 32'd2);
    tick();
    req_v[2] = 1'b1; val_v[2] = 1'b1; tail_v[2] = 1'b1;
    sample();
    check("c_tail_thanks", 32'(thanks), 32'h04);
    tick();
    tail_v[0] = 1'b1;
    sample();
    check("c_rel_locked", 32'(bus.locked), 32'd0);
    tick();
    sample();
    check("after_c_route",  32'(bus.current_route), 32'd0);
    check("after_c_thanks", 32'(thanks), 32'h01);
    tick();
    tick();
    sample();
    check("after_a_route",  32'(bus.current_route), 32'd2);
    check("after_a_thanks", 32'(thanks), 32'h04);
    tick();
    clear_inputs();
    sample();
    check("c_credit", 32'(bus.credit_count), 32'd28);
    tick();

    // Reset in the middle of a D packet, with B and D requesting afterwards.
    req_v[3] = 1'b1; val_v[3] = 1'b1;
    tick();
    sample();
    check("d_thanks", 32'(thanks), 32'h08);
    tick();
    tick();
    reset = 1'b1;
    req_v[1] = 1'b1; val_v[1] = 1'b1;
    tick();
    reset = 1'b0;
    sample();
    check("mid_rst_locked", 32'(bus.locked), 32'd0);
    check("mid_rst_credit", 32'(bus.credit_count), 32'd32);
    check("mid_rst_route",  32'(bus.current_route), 32'd4);
    tick();
    sample();
    check("b_wins_route",  32'(bus.current_route), 32'd1);
    check("b_wins_thanks", 32'(thanks), 32'h02);
    tick();
    clear_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
